// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS channel decoder with word-boundary search.
// Finds the 10-bit word boundary from runs of control tokens, then decodes
// aligned words into an 8-bit video byte or a 2-bit control value.
// Optional build macro: TMDS_SLIP_CNT_EN enables the slip event counter on
// slip_count_out; without it the port is tied to zero.
module tmds_decoder #(
  parameter int unsigned CTRL_RUN   = 16,
  parameter int unsigned SEARCH_WIN = 2048,
  parameter int unsigned LOSS_WIN   = 4096
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [9:0]  tmds_in,
  output logic [7:0]  data_out,
  output logic [1:0]  control_out,
  output logic        ve_out,
  output logic        locked_out,
  output logic [3:0]  offset_out,
  output logic [15:0] slip_count_out
);

  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned WIN_W  = $clog2(SEARCH_WIN);
  localparam int unsigned LOSS_W = $clog2(LOSS_WIN);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(CTRL_RUN);
  localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(SEARCH_WIN - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_WIN - 1);

  typedef enum logic {S_SEARCH, S_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [3:0]        offset_q, offset_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [9:0]        prev_q, prev_d;
  logic [9:0]        aligned_q, aligned_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        control_q, control_d;
  logic              ve_q, ve_d;

  logic              is_ctrl_c;
  logic [1:0]        ctrl_val_c;
  logic [7:0]        dprime_c;
  logic [7:0]        dec_c;
  logic              run_done_c;
  logic [3:0]        next_off_c;

  // Alignment buffer and stage-1 word extraction at the current offset
  always_comb begin
    prev_d    = tmds_in;
    aligned_d = 10'({tmds_in, prev_q} >> offset_q);
  end

  // Token recognition and TMDS data decode of the stage-1 word
  always_comb begin
    is_ctrl_c  = 1'b1;
    ctrl_val_c = 2'b00;
    case (aligned_q)
      10'b1101010100: ctrl_val_c = 2'b00;
      10'b0010101011: ctrl_val_c = 2'b01;
      10'b0101010100: ctrl_val_c = 2'b10;
      10'b1010101011: ctrl_val_c = 2'b11;
      default:        is_ctrl_c  = 1'b0;
    endcase
    dprime_c = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
    dec_c    = '0;
    dec_c[0] = dprime_c[0];
    for (int i = 1; i < 8; i++) begin
      dec_c[i] = aligned_q[8] ? (dprime_c[i] ^ dprime_c[i-1])
                              : ~(dprime_c[i] ^ dprime_c[i-1]);
    end
  end

  // Lock FSM: next state, offset and saturating counters
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    win_d      = win_q;
    loss_d     = loss_q;
    next_off_c = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    if (is_ctrl_c) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end else begin
      run_d = '0;
    end
    run_done_c = (run_d == RUN_MAX);
    case (state_q)
      S_SEARCH: begin
        loss_d = '0;
        if (run_done_c) begin
          state_d = S_LOCKED;
          win_d   = '0;
        end else if (win_q == WIN_MAX) begin
          offset_d = next_off_c;
          run_d    = '0;
          win_d    = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      S_LOCKED: begin
        win_d = '0;
        if (run_done_c) begin
          loss_d = '0;
        end else if (loss_q == LOSS_MAX) begin
          state_d  = S_SEARCH;
          offset_d = next_off_c;
          run_d    = '0;
          loss_d   = '0;
        end else begin
          loss_d = loss_q + LOSS_W'(1);
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  // Output stage: decoded value gated by the lock state taking effect this edge
  always_comb begin
    data_d    = '0;
    control_d = '0;
    ve_d      = 1'b0;
    if (state_d == S_LOCKED) begin
      if (is_ctrl_c) begin
        control_d = ctrl_val_c;
      end else begin
        data_d    = dec_c;
        ve_d      = 1'b1;
        control_d = control_q;
      end
    end
  end

  // State, pipeline and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_SEARCH;
      offset_q  <= '0;
      run_q     <= '0;
      win_q     <= '0;
      loss_q    <= '0;
      prev_q    <= '0;
      aligned_q <= '0;
      data_q    <= '0;
      control_q <= '0;
      ve_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      run_q     <= run_d;
      win_q     <= win_d;
      loss_q    <= loss_d;
      prev_q    <= prev_d;
      aligned_q <= aligned_d;
      data_q    <= data_d;
      control_q <= control_d;
      ve_q      <= ve_d;
    end
  end

  assign data_out    = data_q;
  assign control_out = control_q;
  assign ve_out      = ve_q;
  assign locked_out  = (state_q == S_LOCKED);
  assign offset_out  = offset_q;

`ifdef TMDS_SLIP_CNT_EN
  logic [15:0] slip_q, slip_d;

  // Count offset advances (search timeout or lock loss), saturating
  always_comb begin
    slip_d = slip_q;
    if ((offset_d != offset_q) && (slip_q != 16'hFFFF)) begin
      slip_d = slip_q + 16'd1;
    end
  end

  // Slip counter register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slip_q <= '0;
    end else begin
      slip_q <= slip_d;
    end
  end

  assign slip_count_out = slip_q;
`else
  assign slip_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed testbench for tmds_decoder (CTRL_RUN=4, SEARCH_WIN=32, LOSS_WIN=64).
module tb_tmds_decoder;

  localparam logic [9:0] TOK0 = 10'b1101010100;  // control 00
  localparam logic [9:0] TOK1 = 10'b0010101011;  // control 01
  localparam logic [9:0] D00  = 10'b0100000000;  // data 8'h00
  localparam logic [9:0] DFE  = 10'b1011111111;  // data 8'hFE
  localparam logic [9:0] D01  = 10'b0111111111;  // data 8'h01
  localparam logic [9:0] ROT3 = 10'b1010100110;  // TOK0 stream, boundary at bit 3

`ifdef TMDS_SLIP_CNT_EN
  localparam bit SLIP_EN = 1'b1;
`else
  localparam bit SLIP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [9:0]  tmds;
  logic [7:0]  data_out;
  logic [1:0]  control_out;
  logic        ve_out;
  logic        locked_out;
  logic [3:0]  offset_out;
  logic [15:0] slip_count_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Vector table: word driven, expected {control, ve, data} for that word
  logic [9:0]  vw  [8];
  logic [10:0] vex [8];

  tmds_decoder #(
    .CTRL_RUN  (4),
    .SEARCH_WIN(32),
    .LOSS_WIN  (64)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .tmds_in       (tmds),
    .data_out      (data_out),
    .control_out   (control_out),
    .ve_out        (ve_out),
    .locked_out    (locked_out),
    .offset_out    (offset_out),
    .slip_count_out(slip_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [9:0] word);
    rst  = 1'b1;
    tmds = word;
    step();
    rst  = 1'b0;
  endtask

  task automatic check_vec(input int idx);
    check($sformatf("vec%0d_out", idx), 32'({control_out, ve_out, data_out}), 32'(vex[idx]));
  endtask

  // Drive n table words then the tail word; each result lands 3 steps after drive
  task automatic run_vec(input int n, input logic [9:0] tail);
    for (int i = 0; i < n; i++) begin
      tmds = vw[i];
      step();
      if (i >= 2) check_vec(i - 2);
    end
    tmds = tail;
    step();
    check_vec(n - 2);
    step();
    check_vec(n - 1);
    check("vec_locked", 32'(locked_out), 32'd1);
  endtask

  initial begin
    rst  = 1'b1;
    tmds = TOK0;
    steps(2);

    // Scenario 1: aligned TOK0 stream locks on edge 6 after release
    do_reset(TOK0);
    check("rst_locked", 32'(locked_out), 32'd0);
    check("rst_outs", 32'({control_out, ve_out, data_out}), 32'd0);
    check("rst_offset", 32'(offset_out), 32'd0);
    check("rst_slip", 32'(slip_count_out), 32'd0);
    steps(5);
    check("s1_not_yet", 32'(locked_out), 32'd0);
    step();
    check("s1_locked", 32'(locked_out), 32'd1);
    check("s1_offset", 32'(offset_out), 32'd0);
    check("s1_ctrl_ve", 32'({control_out, ve_out}), 32'd0);
    steps(3);

    // Scenario 3: two data words with 2-cycle pipeline latency
    vw[0] = D00;  vex[0] = {2'b00, 1'b1, 8'h00};
    vw[1] = DFE;  vex[1] = {2'b00, 1'b1, 8'hFE};
    vw[2] = TOK0; vex[2] = {2'b00, 1'b0, 8'h00};
    run_vec(3, TOK0);
    steps(8);

    // Scenario 4: control 01 interleaved with data, control held over data
    vw[0] = TOK1; vex[0] = {2'b01, 1'b0, 8'h00};
    vw[1] = D00;  vex[1] = {2'b01, 1'b1, 8'h00};
    vw[2] = TOK1; vex[2] = {2'b01, 1'b0, 8'h00};
    vw[3] = DFE;  vex[3] = {2'b01, 1'b1, 8'hFE};
    vw[4] = TOK1; vex[4] = {2'b01, 1'b0, 8'h00};
    vw[5] = D01;  vex[5] = {2'b01, 1'b1, 8'h01};
    vw[6] = TOK1; vex[6] = {2'b01, 1'b0, 8'h00};
    vw[7] = TOK1; vex[7] = {2'b01, 1'b0, 8'h00};
    run_vec(8, TOK1);
    steps(8);
    check("s4_ctrl_hold", 32'(control_out), 32'd1);

    // Scenario 6: one-cycle reset while locked, then relock with same timing
    do_reset(TOK0);
    check("s6_locked", 32'(locked_out), 32'd0);
    check("s6_outs", 32'({control_out, ve_out, data_out}), 32'd0);
    check("s6_offset", 32'(offset_out), 32'd0);
    steps(5);
    check("s6_not_yet", 32'(locked_out), 32'd0);
    step();
    check("s6_relocked", 32'(locked_out), 32'd1);
    steps(3);

    // Scenario 5: data-only stream drops lock after LOSS_WIN cycles
    tmds = D01;
    steps(65);
    check("s5_still_locked", 32'(locked_out), 32'd1);
    check("s5_data_pre", 32'({control_out, ve_out, data_out}), 32'({2'b00, 1'b1, 8'h01}));
    step();
    check("s5_unlocked", 32'(locked_out), 32'd0);
    check("s5_offset", 32'(offset_out), 32'd1);
    check("s5_outs_zero", 32'({control_out, ve_out, data_out}), 32'd0);
    check("s5_slip", 32'(slip_count_out), SLIP_EN ? 32'd1 : 32'd0);

    // Scenario 2: boundary at bit 3, three search timeouts then lock
    do_reset(ROT3);
    steps(31);
    check("s2_off0", 32'(offset_out), 32'd0);
    step();
    check("s2_off1", 32'(offset_out), 32'd1);
    check("s2_search_outs", 32'({control_out, ve_out, data_out}), 32'd0);
    steps(32);
    check("s2_off2", 32'(offset_out), 32'd2);
    steps(32);
    check("s2_off3", 32'(offset_out), 32'd3);
    steps(4);
    check("s2_not_yet", 32'(locked_out), 32'd0);
    step();
    check("s2_locked", 32'(locked_out), 32'd1);
    check("s2_lock_off", 32'(offset_out), 32'd3);
    check("s2_ctrl_ve", 32'({control_out, ve_out}), 32'd0);
    check("s2_slip", 32'(slip_count_out), SLIP_EN ? 32'd3 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of tmds_encoder, for loopback and self-check of the HDMI output path.
- Takes raw 10-bit TMDS words from one channel's deserializer, one per clk_pixel.
- Finds the 10-bit word boundary by searching for runs of control tokens, then decodes each aligned word to 8-bit video data or a 2-bit control value.
- One instance per channel (blue, green, red). Outputs feed frame checkers and debug logic in the pixel domain.

Parameters:
- CTRL_RUN, 16: consecutive control tokens at the current offset required to declare lock.
- SEARCH_WIN, 2048: cycles spent at one offset before advancing. Exceeds one 720p line (1650 cycles).
- LOSS_WIN, 4096: cycles allowed in LOCKED without a CTRL_RUN-long control run before lock is dropped.

Ports:
- clk_in, input, 1: pixel clock; all logic on its rising edge.
- rst_in, input, 1: synchronous, active-high reset.
- tmds_in, input, 10: raw deserialized word; bit 0 is the earliest received bit.
- data_out, output, 8: decoded video byte.
- control_out, output, 2: decoded control value {c1,c0}; c0 is hsync and c1 is vsync on the blue channel.
- ve_out, output, 1: data_out is valid video data.
- locked_out, output, 1: word alignment established.
- offset_out, output, 4: current bit offset, 0..9.
- slip_count_out, output, 16: optional; see Optional Feature.

Behaviour:
- Reset (rst_in high at an edge):
  - All outputs go to 0.
  - offset = 0; run and window counters cleared; state = SEARCH.
  - Reset takes effect immediately, mid-lock or mid-search.
- Alignment buffer:
  - prev <= tmds_in every cycle.
  - w = {tmds_in, prev} (20 bits).
  - aligned = w[offset+9 : offset], registered as stage 1.
- Control tokens:
  - 10'b1101010100 -> 00
  - 10'b0010101011 -> 01
  - 10'b0101010100 -> 10
  - 10'b1010101011 -> 11
  - Any other word is data.
- Data decode (stage 2, registered):
  - d' = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = d'[0].
  - For i = 1..7: d[i] = q[8] ? (d'[i] ^ d'[i-1]) : ~(d'[i] ^ d'[i-1]).
- Latency: outputs update 2 cycles after the cycle in which the last bit of a word arrives on tmds_in.
- SEARCH state:
  - run counts consecutive stage-1 control tokens and resets to 0 on any data word.
  - win counts cycles spent at the current offset.
  - When run reaches CTRL_RUN: go to LOCKED at that offset; locked_out rises on the same edge.
  - Otherwise, when win reaches SEARCH_WIN-1: offset advances (9 wraps to 0); run and win clear.
  - If run completes on the same cycle win expires, lock wins.
- LOCKED state:
  - Offset is frozen.
  - loss counts cycles and clears whenever run reaches CTRL_RUN.
  - When loss reaches LOSS_WIN-1: go to SEARCH, locked_out falls, offset advances by 1, counters clear.
- Outputs while locked:
  - Control token: control_out = decoded value, ve_out = 0, data_out = 0.
  - Data word: data_out = d, ve_out = 1, control_out holds its last value.
- Outputs while not locked: data_out, control_out and ve_out are all 0.
- offset_out always shows the live offset.
- Counter widths are sized from the parameters with $clog2; counters saturate and never wrap.

Optional Feature:
- Macro: TMDS_SLIP_CNT_EN.
- Defined: slip_count_out is a 16-bit counter, cleared by reset, that increments on every offset advance and every lock loss. It saturates at 16'hFFFF.
- Undefined: slip_count_out is tied to 0 and no counter logic is generated. The port remains present in both builds.

Test Plan (bench parameters CTRL_RUN=4, SEARCH_WIN=32, LOSS_WIN=64):
1. Continuous 10'b1101010100 at offset 0 after reset -> locked_out=1 on edge 6 after reset release; offset_out=0, control_out=00, ve_out=0.
2. Same token stream rotated so the boundary is at bit 3 -> offsets 0, 1, 2 each time out after 32 cycles; lock at offset_out=3. With TMDS_SLIP_CNT_EN, slip_count_out=3.
3. After lock, send 10'b0100000000 then 10'b1011111111 -> data_out=8'h00 then 8'hFE, ve_out=1 on both, 2-cycle latency, locked_out stays 1.
4. After lock, a stream of 10'b0010101011 interleaved with data -> control_out=01 during tokens and held during data; ve_out toggles with each token/data boundary.
5. After lock, send only data words for 64 cycles -> locked_out falls, offset_out increments by 1, outputs zero. With TMDS_SLIP_CNT_EN, slip_count_out increments.
6. Assert rst_in for 1 cycle while locked -> next edge: all outputs 0, offset_out=0; relock follows the scenario 1 timing.
